nibble_comp_rx: RTL and testbench
=================================

Name: nibble_comp_rx

Overview:
- Receiver for complement-coded operand transfer into the 8-bit ALU.
- Each byte arrives over a 4-bit bus as four beats: each nibble first as true data, then as its bitwise complement.
- The block reassembles the byte, checks every complement pair, and presents the byte on a valid/ready output with per-nibble error flags.
- It also keeps a saturating error count.

Parameters:
- ERR_CNT_W, 8, width of the saturating complement-error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous resync: abort the partial byte and zero err_cnt.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  4  beat payload.
- out_valid  output  1  reassembled byte available.
- out_ready  input  1  consumer accepts the byte when out_valid && out_ready.
- out_data  output  8  reassembled byte {hi_true, lo_true}.
- out_err  output  2  bit0 = low-nibble complement mismatch; bit1 = high-nibble complement mismatch.
- err_cnt  output  ERR_CNT_W  count of bytes with any mismatch; saturates.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous, active-low. Reset drives state=LO_T, out_valid=0, out_data=0, out_err=0, err_cnt=0, and clears the internal nibble registers.
- Beat order per byte: LO_T (low true) -> LO_C (low complement) -> HI_T (high true) -> HI_C (high complement) -> back to LO_T.
  - The FSM advances only on an accepted beat.
  - No gap is required between bytes.
- Capture:
  - LO_T stores lo_t; LO_C stores lo_c.
  - HI_T stores hi_t; HI_C uses in_data directly as hi_c.
- Check:
  - lo_err = (lo_c != ~lo_t).
  - hi_err = (in_data != ~hi_t), evaluated on the HI_C beat.
- in_ready:
  - Forced 0 while clr=1.
  - Otherwise 1 in LO_T, LO_C and HI_T.
  - In HI_C it is (!out_valid || out_ready), so a byte is never overwritten while undelivered.
- Completion, on an accepted HI_C beat at the next edge:
  - out_data = {hi_t, lo_t}, out_err = {hi_err, lo_err}, out_valid = 1.
  - Latency: out_valid rises on the cycle after the 4th beat handshake.
- Output hold: out_data and out_err are stable while out_valid=1 && out_ready=0.
- Drain: an out_ready handshake with no simultaneous completion clears out_valid at the next edge. out_data and out_err keep their last values.
- Simultaneous drain and completion: the new byte loads and out_valid stays 1, giving 1 byte/4 cycles sustained throughput.
- err_cnt:
  - Increments by 1 on each completion with lo_err|hi_err.
  - Holds at 2^ERR_CNT_W-1 (saturates, no wrap).
- clr, synchronous, priority over input:
  - state -> LO_T and the partial nibble registers are discarded.
  - err_cnt -> 0.
  - The output register and out_valid are untouched; a pending byte stays deliverable.
  - A beat presented during clr is not accepted.
- Reset mid-byte or mid-hold: asynchronous return to the reset values; the partial byte and any undelivered byte are lost.
- Error policy: a mismatch never stalls or resyncs the FSM; the next beat is always treated as the next position in the sequence.

Optional Feature:
- Macro: NIBBLE_COMP_RX_ERR_DROP_EN.
- When defined:
  - A completed byte with any mismatch is not loaded and out_valid is not set; err_cnt still increments.
  - out_err is tied to 2'b00.
  - in_ready in HI_C is still gated by output occupancy.
- When undefined: bytes with errors are delivered with out_err flagged, as above.

Test Plan:
- Good byte: reset; send beats 5,A,A,5 with out_ready=1 -> one cycle after beat 4, out_valid=1, out_data=0xA5, out_err=00, err_cnt=0.
- Backpressure: send 0x3C (C,3,3,C) with out_ready=0, then 0x81 (1,E,8,7).
  - in_ready=0 in HI_C of the second byte; out_data holds 0x3C.
  - Raise out_ready -> 0x3C then 0x81 delivered in order, none lost.
- Corrupt high complement: beats C,3,3,D -> out_data=0x3C, out_err=10, err_cnt=1.
  - With NIBBLE_COMP_RX_ERR_DROP_EN: no out_valid, err_cnt=1.
- Saturation: ERR_CNT_W=2; send 5 bytes each with a bad low complement -> err_cnt sequence 1,2,3,3,3.
- Resync: send 2 beats (F,0), pulse clr for 1 cycle with in_valid=1, then send 5,A,A,5.
  - The beat presented during clr is not accepted; err_cnt=0.
  - out_data=0xA5 with out_err=00.
- Async reset mid-hold: out_valid=1 holding 0xA5; drop rst_n between clock edges.
  - out_valid=0 and out_data=0x00 immediately, without waiting for a clock edge.
  - A following byte 5,A,A,5 is received correctly.

Source files
------------

// File: rtl/nibble_comp_rx.sv
// nibble_comp_rx: receives one byte as four 4-bit beats (lo true, lo complement,
// hi true, hi complement). It checks both complement pairs, then presents the byte on
// a valid/ready output with per-nibble error flags. It also keeps a saturating
// count of errored bytes.
// Optional build macro NIBBLE_COMP_RX_ERR_DROP_EN: errored bytes are counted
// but not delivered, and out_err is tied to zero.
module nibble_comp_rx #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           out_data,
  output logic [1:0]           out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {LO_T, LO_C, HI_T, HI_C} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_lo_t, r_lo_c, r_hi_t;
  logic                  r_out_valid;
  logic [7:0]            r_out_data;
  logic [ERR_CNT_W-1:0]  r_err_cnt;

  logic w_in_ready, w_acc, w_done, w_lo_err, w_hi_err, w_any_err, w_load;

  // The final beat waits until the output slot is free or is being drained,
  // so an undelivered byte is never overwritten.
  assign w_in_ready = !clr && ((r_state != HI_C) || !r_out_valid || out_ready);
  assign w_acc      = in_valid && w_in_ready;
  assign w_done     = w_acc && (r_state == HI_C);
  assign w_lo_err   = (r_lo_c != ~r_lo_t);
  assign w_hi_err   = (in_data != ~r_hi_t);
  assign w_any_err  = w_lo_err || w_hi_err;

`ifdef NIBBLE_COMP_RX_ERR_DROP_EN
  assign w_load  = w_done && !w_any_err;
  assign out_err = 2'b00;
`else
  logic [1:0] r_out_err;
  assign w_load  = w_done;
  assign out_err = r_out_err;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LO_T;
    else        r_state <= w_state_nxt;
  end

  // Next state: clr resyncs to LO_T. Otherwise advance once per accepted beat.
  // A mismatch never alters the sequence.
  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = LO_T;
    end else if (w_acc) begin
      unique case (r_state)
        LO_T:    w_state_nxt = LO_C;
        LO_C:    w_state_nxt = HI_T;
        HI_T:    w_state_nxt = HI_C;
        default: w_state_nxt = LO_T;
      endcase
    end
  end

  // Nibble capture. clr discards the partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo_t <= '0;
      r_lo_c <= '0;
      r_hi_t <= '0;
    end else if (clr) begin
      r_lo_t <= '0;
      r_lo_c <= '0;
      r_hi_t <= '0;
    end else if (w_acc) begin
      case (r_state)
        LO_T:    r_lo_t <= in_data;
        LO_C:    r_lo_c <= in_data;
        HI_T:    r_hi_t <= in_data;
        default: ;
      endcase
    end
  end

  // Output slot. A load takes priority over a drain, so back-to-back bytes keep
  // out_valid high. clr does not touch the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= {r_hi_t, r_lo_t};
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifndef NIBBLE_COMP_RX_ERR_DROP_EN
  // Error flags travel with the byte they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_out_err <= '0;
    else if (w_load) r_out_err <= {w_hi_err, w_lo_err};
  end
`endif

  // Saturating count of completed bytes that had any mismatch. clr zeroes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_err_cnt <= '0;
    else if (clr)
      r_err_cnt <= '0;
    else if (w_done && w_any_err && (r_err_cnt != {ERR_CNT_W{1'b1}}))
      r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_nibble_comp_rx.sv
// Bench for nibble_comp_rx. A scoreboard queue holds the expected {err, data}
// for each byte. Tasks push an entry when the final beat is accepted. A monitor
// pops and compares on every output handshake.
module tb_nibble_comp_rx;
  localparam int CW = 2;

  logic          clk = 0, rst_n = 0, clr = 0, in_valid = 0, out_ready = 0;
  logic [3:0]    in_data = '0;
  logic          in_ready, out_valid;
  logic [7:0]    out_data;
  logic [1:0]    out_err;
  logic [CW-1:0] err_cnt;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  nibble_comp_rx #(.ERR_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so the values seen at negedge are the
  // values the next posedge samples.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      logic [9:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor_unexpected: got data=%h err=%b, required no byte", out_data, out_err);
      end else begin
        e = exp_q.pop_front();
        if ({out_err, out_data} !== e) begin
          errors++;
          $display("FAIL monitor_byte: got err=%b data=%h, required err=%b data=%h",
                   out_err, out_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic send_beat(input logic [3:0] d);
    bit ok = 0;
    in_valid = 1; in_data = d;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin @(posedge clk); #1; ok = 1; end
    end
    in_valid = 0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL beat_timeout: beat %h not accepted, required acceptance in 50 cycles", d);
    end
  endtask

  task automatic push_exp(input logic [3:0] lt, lc, ht, hc);
    logic [1:0] e;
    e = {hc != ~ht, lc != ~lt};
`ifdef NIBBLE_COMP_RX_ERR_DROP_EN
    if (e == 2'b00) exp_q.push_back({2'b00, ht, lt});
`else
    exp_q.push_back({e, ht, lt});
`endif
  endtask

  task automatic send_byte(input logic [3:0] lt, lc, ht, hc);
    send_beat(lt); send_beat(lc); send_beat(ht); send_beat(hc);
    push_exp(lt, lc, ht, hc);
  endtask

  task automatic pulse_clr();
    clr = 1; @(posedge clk); #1; clr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h, required 00", out_data); end
    checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL reset_out_err: got %b, required 00", out_err); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
  endtask

  task automatic test_good_byte();
    out_ready = 1;
    send_beat(4'h5); send_beat(4'hA); send_beat(4'hA);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_early_valid: got %b, required 0", out_valid); end
    send_beat(4'h5);
    push_exp(4'h5, 4'hA, 4'hA, 4'h5);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_latency: got %b, required 1", out_valid); end
    checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL good_data: got %h, required a5", out_data); end
    checks++; if (out_err !== 2'b00) begin errors++; $display("FAIL good_err: got %b, required 00", out_err); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL good_err_cnt: got %0d, required 0", err_cnt); end
    idle(3);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_drain: got %b, required 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 0;
    send_byte(4'hC, 4'h3, 4'h3, 4'hC);
    send_beat(4'h1); send_beat(4'hE); send_beat(4'h8);
    in_valid = 1; in_data = 4'h7;
    repeat (3) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
      checks++; if (out_data !== 8'h3C) begin errors++; $display("FAIL bp_hold: got %h, required 3c", out_data); end
    end
    @(posedge clk); #1;
    out_ready = 1;
    send_beat(4'h7);
    push_exp(4'h1, 4'hE, 4'h8, 4'h7);
    checks++; if (out_data !== 8'h81 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_second: got valid=%b data=%h, required valid=1 data=81", out_valid, out_data);
    end
    idle(3);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lost: %0d bytes undelivered, required 0", exp_q.size()); end
  endtask

  task automatic test_corrupt_hi();
    pulse_clr();
    out_ready = 0;
    send_byte(4'hC, 4'h3, 4'h3, 4'hD);
    checks++; if (err_cnt !== 2'd1) begin errors++; $display("FAIL corrupt_err_cnt: got %0d, required 1", err_cnt); end
`ifdef NIBBLE_COMP_RX_ERR_DROP_EN
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL corrupt_drop_valid: got %b, required 0", out_valid); end
`else
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      errors++; $display("FAIL corrupt_data: got valid=%b data=%h, required valid=1 data=3c", out_valid, out_data);
    end
    checks++; if (out_err !== 2'b10) begin errors++; $display("FAIL corrupt_flags: got %b, required 10", out_err); end
`endif
    idle(2);
    out_ready = 1;
    idle(2);
  endtask

  task automatic test_saturation();
    logic [CW-1:0] exp_cnt;
    pulse_clr();
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      send_byte(4'h5, 4'h5, 4'hA, 4'h5);
      exp_cnt = (i < 3) ? CW'(i + 1) : CW'(3);
      checks++; if (err_cnt !== exp_cnt) begin errors++; $display("FAIL sat_cnt_%0d: got %0d, required %0d", i, err_cnt, exp_cnt); end
    end
    idle(2);
  endtask

  task automatic test_resync();
    out_ready = 1;
    send_beat(4'hF); send_beat(4'h0);
    clr = 1; in_valid = 1; in_data = 4'hF;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL resync_in_ready: got %b, required 0", in_ready); end
    @(posedge clk); #1;
    clr = 0; in_valid = 0;
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL resync_err_cnt: got %0d, required 0", err_cnt); end
    send_byte(4'h5, 4'hA, 4'hA, 4'h5);
    checks++; if (out_data !== 8'hA5 || out_err !== 2'b00 || out_valid !== 1'b1) begin
      errors++; $display("FAIL resync_byte: got valid=%b data=%h err=%b, required 1 a5 00", out_valid, out_data, out_err);
    end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL resync_err_cnt2: got %0d, required 0", err_cnt); end
    idle(2);
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    send_byte(4'h5, 4'hA, 4'hA, 4'h5);
    idle(1);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++; $display("FAIL ar_hold: got valid=%b data=%h, required 1 a5", out_valid, out_data);
    end
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b, required 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL ar_data: got %h, required 00", out_data); end
    exp_q.delete();
    #1; rst_n = 1;
    @(posedge clk); #1;
    out_ready = 1;
    send_byte(4'h5, 4'hA, 4'hA, 4'h5);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_err !== 2'b00) begin
      errors++; $display("FAIL ar_after: got valid=%b data=%h err=%b, required 1 a5 00", out_valid, out_data, out_err);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_good_byte();
    test_backpressure();
    test_corrupt_hi();
    test_saturation();
    test_resync();
    test_async_reset();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_queue: %0d bytes undelivered, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end
endmodule
